// File: rtl/ucounter16_arb.sv
// Round-robin sequencer that shares one external down-count timer among NREQ requesters.
// Each granted requester gets its delay loaded, counted to zero, then a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration from ptr
// LOAD   | gnt pulse, preload counter with latched delay
// RUN    | counting down until the counter reads zero
// DONE   | done pulse, rotate ptr past the served requester
module ucounter16_arb #(
  parameter int NREQ = 2,
  parameter int SIZE = 16
) (
  input  logic                 clk,
  input  logic                 _areset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] req_delay,
  input  logic                 abort,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 err,
  output logic                 ctr_load,
  output logic [SIZE-1:0]      ctr_preld_val,
  output logic                 ctr_updown,
  output logic                 ctr_wrapstop,
  output logic                 ctr_aset,
  output logic                 ctr_carry_in,
  input  logic [SIZE-1:0]      ctr_dcount,
  input  logic                 ctr_overflow
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   id_q, id_d;
  logic [SIZE-1:0] dly_q, dly_d;
  logic            err_q, err_d;
  logic [PW-1:0]   win_id;
  logic            win_vld;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Scan from the highest offset down so the nearest set request after ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[wrap_add(ptr_q, k)]) begin
        win_vld = 1'b1;
        win_id  = wrap_add(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    dly_d   = dly_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          dly_d   = req_delay[int'(win_id)*SIZE +: SIZE];
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (ctr_overflow) err_d = 1'b1;
        if (abort) state_d = S_IDLE;
        else if (ctr_dcount == '0) state_d = S_DONE;
      end
      S_DONE: begin
        ptr_d   = wrap_add(id_q, 1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      dly_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dly_q   <= dly_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode only registered state, so reset clears them immediately.
  always_comb begin
    gnt  = '0;
    done = '0;
    if (state_q == S_LOAD) gnt[id_q] = 1'b1;
    if (state_q == S_DONE) done[id_q] = 1'b1;
  end

  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;
  assign ctr_load      = (state_q == S_LOAD);
  assign ctr_preld_val = dly_q;
  assign ctr_carry_in  = (state_q == S_RUN) && (ctr_dcount != '0) && !abort;
  assign ctr_updown    = 1'b0;
  assign ctr_wrapstop  = 1'b0;
  assign ctr_aset      = 1'b0;

endmodule
